hazard_scoreboard: RTL and testbench

//   Parametrised hazard unit for the in-order MIPS pipeline, using the Tuse/Tnew model. It keeps its own

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: keeps shadow destination records for stages E..W, resolves
// D-stage RAW hazards into stall / forward-select, and tracks the HI/LO busy window.
module hazard_scoreboard #(
    parameter int unsigned AW      = 5,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned NSTG    = 3,
    parameter int unsigned TW      = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned SELW    = $clog2(NSTG + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   d_valid,
    input  logic [NSRC-1:0]        d_src_en,
    input  logic [NSRC*AW-1:0]     d_src_addr,
    input  logic [NSRC*TW-1:0]     d_tuse,
    input  logic                   d_dst_we,
    input  logic [AW-1:0]          d_dst_addr,
    input  logic [TW-1:0]          d_tnew,
    input  logic                   d_md_start,
    input  logic                   d_md_div,
    input  logic                   d_md_use,
    input  logic                   flush_e,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   md_busy
);

    localparam int unsigned MDMAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CW    = $clog2(MDMAX + 1);

    // Shadow pipeline records, index 1 = E, NSTG = last tracked stage
    logic          r_v    [1:NSTG];
    logic          r_we   [1:NSTG];
    logic [AW-1:0] r_addr [1:NSTG];
    logic [TW-1:0] r_tnew [1:NSTG];
    logic [CW-1:0] r_md_cnt;

    logic            w_accept;
    logic [NSRC-1:0] w_hazard;
    logic            w_hit      [NSRC];
    logic [SELW-1:0] w_hit_stg  [NSRC];
    logic [TW-1:0]   w_hit_tnew [NSRC];
    logic [AW-1:0]   w_src_addr [NSRC];
    logic [TW-1:0]   w_src_tuse [NSRC];

    assign w_accept = d_valid & ~stall & ~flush_e;
    assign md_busy  = (r_md_cnt != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 1; k <= NSTG; k++) begin
                r_v[k]    <= 1'b0;
                r_we[k]   <= 1'b0;
                r_addr[k] <= '0;
                r_tnew[k] <= '0;
            end
            r_md_cnt <= '0;
        end else begin
            // Stalled or flushed D inserts an all-zero bubble into E
            r_v[1]    <= w_accept;
            r_we[1]   <= w_accept & d_dst_we;
            r_addr[1] <= w_accept ? d_dst_addr : '0;
            r_tnew[1] <= w_accept ? d_tnew : '0;
            for (int unsigned k = 2; k <= NSTG; k++) begin
                r_v[k]    <= r_v[k-1];
                r_we[k]   <= r_we[k-1];
                r_addr[k] <= r_addr[k-1];
                r_tnew[k] <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - 1'b1 : '0;
            end
            if (w_accept && d_md_start) begin
                r_md_cnt <= d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_hazard = '0;
        fwd_sel  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            w_src_addr[i] = d_src_addr[i*AW +: AW];
            w_src_tuse[i] = d_tuse[i*TW +: TW];
            w_hit[i]      = 1'b0;
            w_hit_stg[i]  = '0;
            w_hit_tnew[i] = '0;
            // Scan oldest to youngest so the youngest matching producer overrides
            for (int unsigned j = 0; j < NSTG; j++) begin
                if (r_v[NSTG-j] && r_we[NSTG-j] && (r_addr[NSTG-j] == w_src_addr[i])) begin
                    w_hit[i]      = 1'b1;
                    w_hit_stg[i]  = SELW'(NSTG - j);
                    w_hit_tnew[i] = r_tnew[NSTG-j];
                end
            end
            if (d_src_en[i] && (w_src_addr[i] != '0) && w_hit[i]) begin
                if (w_hit_tnew[i] == '0) begin
                    fwd_sel[i*SELW +: SELW] = w_hit_stg[i];
                end
                if (w_hit_tnew[i] > w_src_tuse[i]) begin
                    w_hazard[i] = 1'b1;
                end
            end
        end
    end

    assign stall = d_valid & ((|w_hazard) | (d_md_use & md_busy));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-derived stall / forward / busy expectations.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset_n;
    logic       d_valid;
    logic [1:0] d_src_en;
    logic [9:0] d_src_addr;
    logic [3:0] d_tuse;
    logic       d_dst_we;
    logic [4:0] d_dst_addr;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       flush_e;
    logic       stall;
    logic [3:0] fwd_sel;
    logic       md_busy;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .AW(5), .NSRC(2), .NSTG(3), .TW(2), .MUL_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_src_en(d_src_en),
        .d_src_addr(d_src_addr), .d_tuse(d_tuse), .d_dst_we(d_dst_we),
        .d_dst_addr(d_dst_addr), .d_tnew(d_tnew), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_use(d_md_use), .flush_e(flush_e),
        .stall(stall), .fwd_sel(fwd_sel), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] en,
                         input logic [4:0] a0, input logic [1:0] u0,
                         input logic [4:0] a1, input logic [1:0] u1,
                         input logic we, input logic [4:0] dst, input logic [1:0] tn,
                         input logic ms, input logic md, input logic mu, input logic fl);
        d_valid    = v;
        d_src_en   = en;
        d_src_addr = {a1, a0};
        d_tuse     = {u1, u0};
        d_dst_we   = we;
        d_dst_addr = dst;
        d_tnew     = tn;
        d_md_start = ms;
        d_md_div   = md;
        d_md_use   = mu;
        flush_e    = fl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd_sel); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    endtask

    task automatic test_load_use();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0);   // lw $8
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall got=%b exp=0", stall); end
        cyc();
        drive(1, 2'b11, 8, 1, 9, 1, 1, 10, 1, 0, 0, 0, 0);  // addu $10,$8,$9
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL lu_fwd_e got=%b exp=0000", fwd_sel); end
        cyc();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL lu_fwd_m got=%b exp=0000", fwd_sel); end
        cyc();
        // lw two stages ahead (bubble between), addu in E with tnew 1
        drive(1, 2'b11, 8, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_sel !== 4'b0011) begin errors++; $display("FAIL lu_bubble_fwd got=%b exp=0011", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_follow_stall got=%b exp=0", stall); end
        cyc();
        idle(3);
    endtask

    task automatic test_alu_beq();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);   // addu $3
        cyc();
        drive(1, 2'b11, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);   // beq $3,$4
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL beq_stall got=%b exp=1", stall); end
        cyc();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL beq_release got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL beq_fwd_m got=%b exp=0010", fwd_sel); end
        cyc();
        drive(1, 2'b10, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_sel !== 4'b1100) begin errors++; $display("FAIL beq_fwd_w got=%b exp=1100", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL beq_w_stall got=%b exp=0", stall); end
        cyc();
        idle(3);
    endtask

    task automatic test_youngest();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);   // writes $0, slow tnew
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 2'b11, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL young_fwd got=%b exp=0001", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL young_zero_stall got=%b exp=0", stall); end
        drive(1, 2'b00, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL young_disabled got=%b exp=0000", fwd_sel); end
        idle(3);
    endtask

    task automatic run_md(input logic is_div, input int exp_cycles, input string nm);
        int n;
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, is_div, 1, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s_start_stall got=%b exp=0", nm, stall); end
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);   // mfhi $2
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", nm, md_busy); end
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        checks++; if (n != exp_cycles) begin errors++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", nm, n, exp_cycles); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", nm, md_busy); end
        cyc();
        idle(1);
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL %s_no_reload got=%b exp=0", nm, md_busy); end
        idle(2);
    endtask

    task automatic test_md();
        run_md(1'b0, 5, "mult");
        run_md(1'b1, 10, "div");
    endtask

    task automatic test_flush();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 1);   // flushed writer of $7
        cyc();
        drive(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_dep_stall got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL flush_dep_fwd got=%b exp=0000", fwd_sel); end
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0);
        cyc();
        // addu $11,$6,$11 while stalled and flushed
        drive(1, 2'b11, 6, 0, 11, 0, 1, 11, 0, 0, 0, 0, 1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sf_stall got=%b exp=1", stall); end
        cyc();
        drive(1, 2'b11, 6, 0, 11, 0, 1, 11, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sf_release got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL sf_no_double got=%b exp=0010", fwd_sel); end
        cyc();
        drive(1, 2'b01, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL sf_issue_once got=%b exp=0001", fwd_sel); end
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);   // div
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 2'b00, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0);
        cyc();
        drive(1, 2'b11, 12, 0, 14, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got=%b exp=1", stall); end
        checks++; if (fwd_sel !== 4'b0111) begin errors++; $display("FAIL rm_pre_fwd got=%b exp=0111", fwd_sel); end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", md_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_stall got=%b exp=0", stall); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rm_fwd got=%b exp=0000", fwd_sel); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_beq();
        test_youngest();
        test_md();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
